// File: rtl/pc_out_unpacker_pkg.sv
// Shared definitions for the FPGA->PC word stream. The serializer uses the
// same codes, so both ends of the link stay in step.
//   - PC_* : 8-bit code field values
//   - state_t : reassembly FSM states
//   - hb_rec_t / sf_rec_t : full-width records rebuilt from two words
package pc_out_unpacker_pkg;

  localparam int PC_CODE_W = 8;
  localparam int PC_DATA_W = 24;
  localparam int TM_TIME_W = 48;
  localparam int SF_FILT_W = 10;
  localparam int SF_STATE_W = 27;

  localparam logic [PC_CODE_W-1:0] PC_HB_LO = 8'h40;
  localparam logic [PC_CODE_W-1:0] PC_HB_HI = 8'h41;
  localparam logic [PC_CODE_W-1:0] PC_SF_LO = 8'h42;
  localparam logic [PC_CODE_W-1:0] PC_SF_HI = 8'h43;
  localparam logic [PC_CODE_W-1:0] PC_NOP   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HB_PART = 2'd1,
    ST_SF_PART = 2'd2
  } state_t;

  typedef logic [TM_TIME_W-1:0] hb_rec_t;

  typedef struct packed {
    logic [SF_FILT_W-1:0]  filt_idx;
    logic [SF_STATE_W-1:0] state;
  } sf_rec_t;

endpackage

// File: rtl/pc_out_unpacker_out_slot.sv
// Single-entry registered channel buffer.
//   clk, reset : clock, synchronous active-high reset (clears valid only)
//   i_load     : write i_d into the slot; caller guarantees the slot is
//                empty or draining in the same cycle
//   o_v, o_d   : channel master valid/data, both straight from registers
//   i_a        : channel accept from the consumer
module out_slot #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic         o_v,
  output logic [N-1:0] o_d,
  input  logic         i_a
);

  logic         r_v_p1;
  logic [N-1:0] r_d_p1;

  // Load wins over drain so a same-cycle drain+refill stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v_p1 <= 1'b0;
    end else if (i_load) begin
      r_v_p1 <= 1'b1;
    end else if (i_a) begin
      r_v_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_d_p1 <= i_d;
    end
  end

  assign o_v = r_v_p1;
  assign o_d = r_d_p1;

endmodule

// File: rtl/pc_out_unpacker.sv
// Receiving end of the FPGA->PC word stream. Rebuilds two-word heartbeat
// and spike-filter messages into full-width records, passes other codes
// through unchanged and drops NOP fill.
//   clk, reset          : clock, synchronous active-high reset
//   in_v/in_d/in_a      : packed {code, data} word stream (slave)
//   hb_out_v/_d/_a      : reassembled heartbeat time (master)
//   sf_out_v/_d/_a      : {filt_idx, state} (master)
//   bd_out_v/_d/_a      : passthrough word (master)
//   err_ct              : saturating protocol-error count
module pc_out_unpacker
  import pc_out_unpacker_pkg::*;
#(
  parameter int NPCcode    = 8,
  parameter int NPCdata    = 24,
  parameter int N_TM_time  = 48,
  parameter int N_SF_filts = 10,
  parameter int N_SF_state = 27,
  parameter int Nerr       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_v,
  input  logic [NPCcode+NPCdata-1:0]       in_d,
  output logic                             in_a,
  output logic                             hb_out_v,
  output logic [N_TM_time-1:0]             hb_out_d,
  input  logic                             hb_out_a,
  output logic                             sf_out_v,
  output logic [N_SF_filts+N_SF_state-1:0] sf_out_d,
  input  logic                             sf_out_a,
  output logic                             bd_out_v,
  output logic [NPCcode+NPCdata-1:0]       bd_out_d,
  input  logic                             bd_out_a,
  output logic [Nerr-1:0]                  err_ct
);

  function automatic logic [Nerr-1:0] sat_inc(input logic [Nerr-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  state_t                 r_state;
  logic [NPCdata-1:0]     r_lo;
  logic [Nerr-1:0]        r_err;

  logic [NPCcode-1:0]     w_code;
  logic [NPCdata-1:0]     w_data;
  logic                   w_hb_lo, w_hb_hi, w_sf_lo, w_sf_hi, w_nop, w_bd;
  logic                   w_is_lo, w_is_hi, w_hi_match;
  logic                   w_hb_room, w_sf_room, w_bd_room;
  logic                   w_xfer, w_err;
  logic                   w_hb_load, w_sf_load, w_bd_load;
  logic [2*NPCdata-1:0]   w_full;

  // ---- decode of the incoming word ----
  assign w_code  = in_d[NPCcode+NPCdata-1 -: NPCcode];
  assign w_data  = in_d[NPCdata-1:0];
  assign w_hb_lo = (w_code == PC_HB_LO);
  assign w_hb_hi = (w_code == PC_HB_HI);
  assign w_sf_lo = (w_code == PC_SF_LO);
  assign w_sf_hi = (w_code == PC_SF_HI);
  assign w_nop   = (w_code == PC_NOP);
  assign w_is_lo = w_hb_lo | w_sf_lo;
  assign w_is_hi = w_hb_hi | w_sf_hi;
  assign w_bd    = ~(w_is_lo | w_is_hi | w_nop);

  assign w_hi_match = (w_hb_hi && r_state == ST_HB_PART) ||
                      (w_sf_hi && r_state == ST_SF_PART);

  // A slot can take a new word if empty or being emptied this cycle.
  assign w_hb_room = ~hb_out_v | hb_out_a;
  assign w_sf_room = ~sf_out_v | sf_out_a;
  assign w_bd_room = ~bd_out_v | bd_out_a;

  // HI words stall on their own slot even when they will be dropped as
  // errors, keeping in_a a function of code and slot only.
  always_comb begin
    in_a = 1'b0;
    if (!reset) begin
      if (w_hb_hi)      in_a = w_hb_room;
      else if (w_sf_hi) in_a = w_sf_room;
      else if (w_bd)    in_a = w_bd_room;
      else              in_a = 1'b1;
    end
  end

  assign w_xfer    = in_v & in_a;
  assign w_err     = w_xfer & ((w_is_hi & ~w_hi_match) | (w_is_lo & (r_state != ST_IDLE)));
  assign w_hb_load = w_xfer & w_hb_hi & (r_state == ST_HB_PART);
  assign w_sf_load = w_xfer & w_sf_hi & (r_state == ST_SF_PART);
  assign w_bd_load = w_xfer & w_bd;

  // Record is {hi, lo} truncated to the record width.
  assign w_full = {w_data, r_lo};

  // ---- stage p0 -> p1: FSM, low-half capture, error count ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lo    <= '0;
      r_err   <= '0;
    end else begin
      if (w_xfer) begin
        if (w_is_lo) begin
          r_lo    <= w_data;
          r_state <= w_hb_lo ? ST_HB_PART : ST_SF_PART;
        end else if (w_is_hi) begin
          r_state <= ST_IDLE;
        end
      end
      if (w_err) begin
        r_err <= sat_inc(r_err);
      end
    end
  end

  assign err_ct = r_err;

  // ---- stage p1: one-deep output slots ----
  out_slot #(.N(N_TM_time)) u_hb_slot (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_hb_load),
    .i_d    (w_full[N_TM_time-1:0]),
    .o_v    (hb_out_v),
    .o_d    (hb_out_d),
    .i_a    (hb_out_a)
  );

  out_slot #(.N(N_SF_filts+N_SF_state)) u_sf_slot (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_sf_load),
    .i_d    (w_full[N_SF_filts+N_SF_state-1:0]),
    .o_v    (sf_out_v),
    .o_d    (sf_out_d),
    .i_a    (sf_out_a)
  );

  out_slot #(.N(NPCcode+NPCdata)) u_bd_slot (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_bd_load),
    .i_d    (in_d),
    .o_v    (bd_out_v),
    .o_d    (bd_out_d),
    .i_a    (bd_out_a)
  );

endmodule

// File: tb/tb_pc_out_unpacker.sv
module tb_pc_out_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic [31:0] in_d;
  logic        in_a;
  logic        hb_out_v;
  logic [47:0] hb_out_d;
  logic        hb_out_a;
  logic        sf_out_v;
  logic [36:0] sf_out_d;
  logic        sf_out_a;
  logic        bd_out_v;
  logic [31:0] bd_out_d;
  logic        bd_out_a;
  logic [7:0]  err_ct;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_out_unpacker dut (
    .clk      (clk),
    .reset    (reset),
    .in_v     (in_v),
    .in_d     (in_d),
    .in_a     (in_a),
    .hb_out_v (hb_out_v),
    .hb_out_d (hb_out_d),
    .hb_out_a (hb_out_a),
    .sf_out_v (sf_out_v),
    .sf_out_d (sf_out_d),
    .sf_out_a (sf_out_a),
    .bd_out_v (bd_out_v),
    .bd_out_d (bd_out_d),
    .bd_out_a (bd_out_a),
    .err_ct   (err_ct)
  );

  task automatic do_reset();
    reset = 1'b1;
    in_v  = 1'b0;
    in_d  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Offers one word and returns 1 time unit after the edge that took it.
  task automatic send_word(input logic [7:0] c, input logic [23:0] d);
    int n;
    n = 0;
    in_v = 1'b1;
    in_d = {c, d};
    @(negedge clk);
    while (!in_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_a) begin
      bad++;
      $display("FAIL send_timeout code=%h in_a=%b required 1", c, in_a);
      in_v = 1'b0;
    end
    @(posedge clk);
    #1 in_v = 1'b0;
  endtask

  task automatic test_reset();
    hb_out_a = 1'b1; sf_out_a = 1'b1; bd_out_a = 1'b1;
    reset = 1'b1; in_v = 1'b1; in_d = {8'h40, 24'h0};
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_a !== 1'b0) begin bad++; $display("FAIL rst_in_a got=%b want=0", in_a); end
    @(posedge clk);
    #1 reset = 1'b0; in_v = 1'b0;
    total++;
    if ({hb_out_v, sf_out_v, bd_out_v} !== 3'b000) begin
      bad++; $display("FAIL rst_valids got=%b want=000", {hb_out_v, sf_out_v, bd_out_v});
    end
    total++;
    if (err_ct !== 8'h00) begin bad++; $display("FAIL rst_err got=%h want=00", err_ct); end
  endtask

  task automatic test_hb_basic();
    do_reset();
    send_word(8'h40, 24'h123456);
    send_word(8'h41, 24'hABCDEF);
    total++;
    if (hb_out_v !== 1'b1 || hb_out_d !== 48'hABCDEF123456) begin
      bad++; $display("FAIL hb_rec got v=%b d=%h want v=1 d=abcdef123456", hb_out_v, hb_out_d);
    end
    total++;
    if (err_ct !== 8'h00) begin bad++; $display("FAIL hb_err got=%h want=00", err_ct); end
    @(posedge clk); #1;
    total++;
    if (hb_out_v !== 1'b0) begin bad++; $display("FAIL hb_drain got v=%b want=0", hb_out_v); end
  endtask

  task automatic test_sf_basic();
    do_reset();
    send_word(8'h42, 24'h00FFFF);
    send_word(8'h43, {11'd0, 10'd5, 3'b101});
    total++;
    if (sf_out_v !== 1'b1 || sf_out_d !== {10'd5, 27'h500FFFF}) begin
      bad++; $display("FAIL sf_rec got v=%b d=%h want v=1 d=%h", sf_out_v, sf_out_d, {10'd5, 27'h500FFFF});
    end
    total++;
    if (hb_out_v !== 1'b0 || bd_out_v !== 1'b0) begin
      bad++; $display("FAIL sf_others got hb=%b bd=%b want 0 0", hb_out_v, bd_out_v);
    end
    total++;
    if (err_ct !== 8'h00) begin bad++; $display("FAIL sf_err got=%h want=00", err_ct); end
  endtask

  task automatic test_hi_idle_err();
    do_reset();
    send_word(8'h41, 24'h000001);
    total++;
    if (hb_out_v !== 1'b0 || err_ct !== 8'h01) begin
      bad++; $display("FAIL hi_idle got hb_v=%b err=%h want 0 01", hb_out_v, err_ct);
    end
    send_word(8'h42, 24'h000777);
    send_word(8'h40, 24'h000010);
    send_word(8'h41, 24'h000020);
    total++;
    if (hb_out_v !== 1'b1 || hb_out_d !== 48'h000020000010) begin
      bad++; $display("FAIL lo_restart got v=%b d=%h want v=1 d=000020000010", hb_out_v, hb_out_d);
    end
    total++;
    if (err_ct !== 8'h02 || sf_out_v !== 1'b0) begin
      bad++; $display("FAIL lo_restart_err got err=%h sf_v=%b want 02 0", err_ct, sf_out_v);
    end
  endtask

  task automatic test_hb_backpressure();
    do_reset();
    hb_out_a = 1'b0;
    send_word(8'h40, 24'h111111);
    send_word(8'h41, 24'h222222);
    send_word(8'h40, 24'h333333);
    in_v = 1'b1;
    in_d = {8'h41, 24'h444444};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_a !== 1'b0) begin bad++; $display("FAIL bp_stall%0d got in_a=%b want=0", i, in_a); end
      @(posedge clk); #1;
    end
    total++;
    if (hb_out_v !== 1'b1 || hb_out_d !== 48'h222222111111) begin
      bad++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=222222111111", hb_out_v, hb_out_d);
    end
    @(negedge clk);
    hb_out_a = 1'b1;
    #1;
    total++;
    if (in_a !== 1'b1) begin bad++; $display("FAIL bp_drain_a got in_a=%b want=1", in_a); end
    @(posedge clk); #1;
    in_v = 1'b0;
    total++;
    if (hb_out_v !== 1'b1 || hb_out_d !== 48'h444444333333) begin
      bad++; $display("FAIL bp_refill got v=%b d=%h want v=1 d=444444333333", hb_out_v, hb_out_d);
    end
    @(posedge clk); #1;
    total++;
    if (hb_out_v !== 1'b0 || err_ct !== 8'h00) begin
      bad++; $display("FAIL bp_final got v=%b err=%h want 0 00", hb_out_v, err_ct);
    end
  endtask

  task automatic test_bd_interleave();
    do_reset();
    send_word(8'h42, 24'h000ABC);
    send_word(8'hFF, 24'hDEAD00);
    total++;
    if (bd_out_v !== 1'b0) begin bad++; $display("FAIL nop_drop got bd_v=%b want=0", bd_out_v); end
    send_word(8'h05, 24'h123456);
    total++;
    if (bd_out_v !== 1'b1 || bd_out_d !== 32'h05123456) begin
      bad++; $display("FAIL bd_pass got v=%b d=%h want v=1 d=05123456", bd_out_v, bd_out_d);
    end
    send_word(8'h43, {11'd0, 10'd3, 3'b010});
    total++;
    if (sf_out_v !== 1'b1 || sf_out_d !== {10'd3, 27'h2000ABC}) begin
      bad++; $display("FAIL bd_sf_rec got v=%b d=%h want v=1 d=%h", sf_out_v, sf_out_d, {10'd3, 27'h2000ABC});
    end
    total++;
    if (err_ct !== 8'h00 || bd_out_v !== 1'b0) begin
      bad++; $display("FAIL bd_err got err=%h bd_v=%b want 00 0", err_ct, bd_out_v);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int i = 0; i < 3; i++) send_word(8'h43, 24'h000000);
    total++;
    if (err_ct !== 8'h03) begin bad++; $display("FAIL err_count3 got=%h want=03", err_ct); end
    for (int i = 3; i < 255; i++) send_word(8'h41, 24'h000000);
    total++;
    if (err_ct !== 8'hFF) begin bad++; $display("FAIL err_count255 got=%h want=ff", err_ct); end
    for (int i = 255; i < 300; i++) send_word(8'h41, 24'h000000);
    total++;
    if (err_ct !== 8'hFF || hb_out_v !== 1'b0) begin
      bad++; $display("FAIL err_sat got err=%h hb_v=%b want ff 0", err_ct, hb_out_v);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hb_out_a = 1'b0;
    send_word(8'h43, 24'h000000);
    send_word(8'h40, 24'h000001);
    send_word(8'h41, 24'h000002);
    send_word(8'h42, 24'h0000AA);
    total++;
    if (hb_out_v !== 1'b1 || err_ct !== 8'h01) begin
      bad++; $display("FAIL mid_setup got hb_v=%b err=%h want 1 01", hb_out_v, err_ct);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (in_a !== 1'b0) begin bad++; $display("FAIL mid_rst_a got in_a=%b want=0", in_a); end
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({hb_out_v, sf_out_v, bd_out_v} !== 3'b000 || err_ct !== 8'h00) begin
      bad++; $display("FAIL mid_rst got v=%b err=%h want 000 00", {hb_out_v, sf_out_v, bd_out_v}, err_ct);
    end
    hb_out_a = 1'b1;
    send_word(8'h43, {11'd0, 10'd7, 3'b000});
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({hb_out_v, sf_out_v, bd_out_v} !== 3'b000 || err_ct !== 8'h01) begin
      bad++; $display("FAIL mid_partial got v=%b err=%h want 000 01", {hb_out_v, sf_out_v, bd_out_v}, err_ct);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_v = 1'b0;
    in_d = '0;
    hb_out_a = 1'b1;
    sf_out_a = 1'b1;
    bd_out_a = 1'b1;
    test_reset();
    test_hb_basic();
    test_sf_basic();
    test_hi_idle_err();
    test_hb_backpressure();
    test_bd_interleave();
    test_err_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
